// File: rtl/md5_msg_sched_if.sv
// md5_msg_sched_if: block-load stream (in_*) and per-round field stream (out_*)
// of the MD5 message scheduler, plus the busy status flag.
interface md5_msg_sched_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_m;
   logic [31:0] out_k;
   logic [4:0]  out_s;
   logic [5:0]  out_round;
   logic        out_last;
   logic        busy;

   // scheduler side
   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, out_m, out_k, out_s, out_round, out_last, busy
   );

   // feeder / round-stage side
   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, out_m, out_k, out_s, out_round, out_last, busy
   );
endinterface

// File: rtl/md5_msg_sched.sv
// md5_msg_sched: buffers one 512-bit block (16 x 32-bit words) and then emits
// one MD5 round's (m, k, s, round) per handshake, NUM_ROUNDS rounds per block.
// Optional build macro MD5_SCHED_PREFETCH_EN adds a shadow buffer so the next
// block loads while the current one is being emitted.
module md5_msg_sched #(
   parameter int NUM_ROUNDS = 64
) (
   input  logic            clk,
   input  logic            rst,
   md5_msg_sched_if.slave  io
);

   localparam logic [5:0] LAST_R = 6'(NUM_ROUNDS - 1);
   localparam logic [0:0] LOAD   = 1'b0;
   localparam logic [0:0] EMIT   = 1'b1;

   // K[r] = floor(|sin(r+1)| * 2^32)
   localparam logic [31:0] KROM [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // message word index for round r; only r mod 16 matters inside each group
   function automatic logic [3:0] g_idx(input logic [5:0] r);
      logic [7:0] x, t;
      x = {4'd0, r[3:0]};
      case (r[5:4])
         2'd0:    t = x;
         2'd1:    t = x * 8'd5 + 8'd1;
         2'd2:    t = x * 8'd3 + 8'd5;
         default: t = x * 8'd7;
      endcase
      return t[3:0];
   endfunction

   // rotate amount: row = group of 16 rounds, column = r mod 4
   function automatic logic [4:0] s_amt(input logic [5:0] r);
      logic [4:0] s;
      s = 5'd0;
      case ({r[5:4], r[1:0]})
         4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
         4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
         4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
         4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  4'hf: s = 5'd21;
         default: s = 5'd0;
      endcase
      return s;
   endfunction

   logic [0:0]        state;
   logic [3:0]        wcnt;
   logic [5:0]        rcnt;
   logic              acc, hs, last_hs, swap, ld_en;
   logic [5:0]        ld_idx;
   logic [15:0][31:0] act_buf, new_buf, ld_buf;

`ifdef MD5_SCHED_PREFETCH_EN
   logic [1:0][15:0][31:0] mbuf;
   logic                   act, fill, shd_full;
`else
   logic [15:0][31:0]      mbuf;
`endif

   // handshakes, buffer selection and which round's fields load next edge
   always_comb begin
      acc     = io.in_valid & io.in_ready;
      hs      = io.out_valid & io.out_ready;
      last_hs = hs & (rcnt == LAST_R);
`ifdef MD5_SCHED_PREFETCH_EN
      act_buf = mbuf[act];
      new_buf = mbuf[fill];
      // shadow completing on the same edge as the last round still counts as full
      swap    = (state == EMIT) & (shd_full | (acc & (wcnt == 4'd15)));
`else
      act_buf = mbuf;
      new_buf = mbuf;
      swap    = 1'b0;
`endif
      ld_en  = 1'b0;
      ld_idx = 6'd0;
      ld_buf = new_buf;
      if (state == LOAD) begin
         ld_en = acc & (wcnt == 4'd15);
      end else if (hs) begin
         if (!last_hs) begin
            ld_en  = 1'b1;
            ld_idx = rcnt + 6'd1;
            ld_buf = act_buf;
         end else begin
            ld_en = swap;
         end
      end
   end

   // block storage; contents are don't-care until fully written
   always_ff @(posedge clk) begin
`ifdef MD5_SCHED_PREFETCH_EN
      if (acc) mbuf[fill][wcnt] <= io.in_word;
`else
      if (acc) mbuf[wcnt] <= io.in_word;
`endif
   end

   // LOAD/EMIT control: word counter, round counter and stream flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= LOAD;
         wcnt         <= 4'd0;
         rcnt         <= 6'd0;
         io.in_ready  <= 1'b0;
         io.out_valid <= 1'b0;
         io.busy      <= 1'b0;
`ifdef MD5_SCHED_PREFETCH_EN
         act          <= 1'b0;
         fill         <= 1'b0;
         shd_full     <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               io.in_ready <= 1'b1;
               if (acc) begin
                  io.busy <= 1'b1;
                  wcnt    <= wcnt + 4'd1;
                  if (wcnt == 4'd15) begin
                     state        <= EMIT;
                     rcnt         <= 6'd0;
                     io.out_valid <= 1'b1;
`ifdef MD5_SCHED_PREFETCH_EN
                     act          <= fill;
                     fill         <= ~fill;
                     shd_full     <= 1'b0;
`else
                     io.in_ready  <= 1'b0;
`endif
                  end
               end
            end
            default: begin
`ifdef MD5_SCHED_PREFETCH_EN
               if (acc) begin
                  wcnt <= wcnt + 4'd1;
                  if (wcnt == 4'd15) begin
                     shd_full    <= 1'b1;
                     io.in_ready <= 1'b0;
                  end
               end
`endif
               if (hs) begin
                  if (last_hs) begin
                     rcnt <= 6'd0;
                     if (swap) begin
`ifdef MD5_SCHED_PREFETCH_EN
                        act         <= fill;
                        fill        <= ~fill;
                        shd_full    <= 1'b0;
                        io.in_ready <= 1'b1;
`endif
                     end else begin
                        state        <= LOAD;
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
`ifdef MD5_SCHED_PREFETCH_EN
                        // a partly filled shadow keeps the block in flight
                        io.busy      <= acc | (wcnt != 4'd0);
`else
                        io.busy      <= 1'b0;
`endif
                     end
                  end else begin
                     rcnt <= rcnt + 6'd1;
                  end
               end
            end
         endcase
      end
   end

   // registered round fields; held while the round stage stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io.out_m     <= 32'd0;
         io.out_k     <= 32'd0;
         io.out_s     <= 5'd0;
         io.out_round <= 6'd0;
         io.out_last  <= 1'b0;
      end else if (ld_en) begin
         io.out_m     <= ld_buf[g_idx(ld_idx)];
         io.out_k     <= KROM[ld_idx];
         io.out_s     <= s_amt(ld_idx);
         io.out_round <= ld_idx;
         io.out_last  <= (ld_idx == LAST_R);
      end
   end

endmodule

// File: tb/tb_md5_msg_sched.sv
// tb_md5_msg_sched: directed sequence with random data, random valid gaps and
// random back-pressure; expected fields come from MD5's index/shift/sine rules.
module tb_md5_msg_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   md5_msg_sched_if if64();
   md5_msg_sched_if if16();

   md5_msg_sched #(.NUM_ROUNDS(64)) dut   (.clk(clk), .rst(rst), .io(if64));
   md5_msg_sched #(.NUM_ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .io(if16));

   // sel picks which DUT the stimulus drives and the checks observe
   logic        sel = 1'b0;
   logic        d_valid = 1'b0;
   logic [31:0] d_word = 32'd0;
   logic        d_ready = 1'b0;

   assign if64.in_valid  = d_valid & ~sel;
   assign if16.in_valid  = d_valid & sel;
   assign if64.in_word   = d_word;
   assign if16.in_word   = d_word;
   assign if64.out_ready = d_ready & ~sel;
   assign if16.out_ready = d_ready & sel;

   logic        o_valid, o_in_ready, o_last, o_busy;
   logic [31:0] o_m, o_k;
   logic [4:0]  o_s;
   logic [5:0]  o_round;
   assign o_valid    = sel ? if16.out_valid : if64.out_valid;
   assign o_in_ready = sel ? if16.in_ready  : if64.in_ready;
   assign o_last     = sel ? if16.out_last  : if64.out_last;
   assign o_busy     = sel ? if16.busy      : if64.busy;
   assign o_m        = sel ? if16.out_m     : if64.out_m;
   assign o_k        = sel ? if16.out_k     : if64.out_k;
   assign o_s        = sel ? if16.out_s     : if64.out_s;
   assign o_round    = sel ? if16.out_round : if64.out_round;

   int          total = 0;
   int          bad   = 0;
   int          nr    = 64;
   logic [31:0] M [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference rules
   function automatic int g_ref(input int r);
      if (r < 16) return r;
      if (r < 32) return (5 * r + 1) % 16;
      if (r < 48) return (3 * r + 5) % 16;
      return (7 * r) % 16;
   endfunction

   function automatic int s_ref(input int r);
      int st [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
      return st[(r / 16) * 4 + (r % 4)];
   endfunction

   function automatic logic [31:0] k_ref(input int r);
      real    x;
      longint v;
      x = $sin(real'(r + 1));
      if (x < 0.0) x = -x;
      v = longint'($floor(x * 4294967296.0));
      return v[31:0];
   endfunction

   task automatic check_round(input int er);
      chk($sformatf("m_r%0d", er),     64'(o_m),     64'(M[g_ref(er)]));
      chk($sformatf("k_r%0d", er),     64'(o_k),     64'(k_ref(er)));
      chk($sformatf("s_r%0d", er),     64'(o_s),     64'(s_ref(er)));
      chk($sformatf("round_r%0d", er), 64'(o_round), 64'(er));
      chk($sformatf("last_r%0d", er),  64'(o_last),  64'(er == nr - 1));
      // literal spot values of the constant table
      if (er == 0)  chk("k_lit_r0",  64'(o_k), 64'h d76aa478);
      if (er == 16) chk("k_lit_r16", 64'(o_k), 64'h f61e2562);
      if (er == 32) chk("k_lit_r32", 64'(o_k), 64'h fffa3942);
      if (er == 48) chk("k_lit_r48", 64'(o_k), 64'h f4292244);
      if (er == 63) chk("k_lit_r63", 64'(o_k), 64'h eb86d391);
   endtask

   // feed M[0..15]; rnd inserts random valid gaps. Called and returns at a negedge.
   task automatic load_block(input bit rnd);
      int idx = 0;
      int cyc = 0;
      while (idx < 16 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         chk("load_out_valid", 64'(o_valid), 64'd0);
         chk("load_busy", 64'(o_busy), 64'(idx > 0));
         d_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         d_word  = d_valid ? M[idx] : $urandom;
         if (d_valid && o_in_ready) idx++;
      end
      if (idx < 16) chk("load_timeout", 64'(idx), 64'd16);
      @(negedge clk);
      d_valid = 1'b0;
      chk("latency_out_valid", 64'(o_valid), 64'd1);
      chk("latency_busy", 64'(o_busy), 64'd1);
      chk("emit_in_ready", 64'(o_in_ready), 64'd0);
   endtask

   // consume rounds 0..stop_at-1; stall adds random back-pressure and a 5-cycle hold at r=20
   task automatic run_rounds(input int stop_at, input bit stall);
      int er = 0;
      int cyc = 0;
      int hold = 0;
      while (er < stop_at && cyc < 3000) begin
         chk("emit_out_valid", 64'(o_valid), 64'd1);
         check_round(er);
         chk("emit_in_ready", 64'(o_in_ready), 64'd0);
         chk("emit_busy", 64'(o_busy), 64'd1);
         d_valid = 1'($urandom_range(0, 1));
         d_word  = $urandom;
         if (stall && er == 20 && hold < 5) begin
            d_ready = 1'b0;
            hold++;
         end else begin
            d_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (d_ready && o_valid) er++;
         @(negedge clk);
         cyc++;
      end
      d_ready = 1'b0;
      d_valid = 1'b0;
      if (er < stop_at) chk("emit_timeout", 64'(er), 64'(stop_at));
   endtask

   task automatic post_block_checks();
      chk("done_out_valid", 64'(o_valid), 64'd0);
      chk("done_busy", 64'(o_busy), 64'd0);
      chk("done_in_ready", 64'(o_in_ready), 64'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready",  64'(o_in_ready), 64'd0);
      chk("rst_out_valid", 64'(o_valid),    64'd0);
      chk("rst_out_m",     64'(o_m),        64'd0);
      chk("rst_out_k",     64'(o_k),        64'd0);
      chk("rst_out_s",     64'(o_s),        64'd0);
      chk("rst_out_round", 64'(o_round),    64'd0);
      chk("rst_out_last",  64'(o_last),     64'd0);
      chk("rst_busy",      64'(o_busy),     64'd0);
      rst = 1'b0;
      chk("rel_in_ready_same", 64'(o_in_ready), 64'd0);
      @(negedge clk);
      chk("rel_in_ready_next", 64'(o_in_ready), 64'd1);

      // block A: M[i] = i, no stalls
      for (int i = 0; i < 16; i++) M[i] = 32'(i);
      nr = 64;
      load_block(1'b0);
      run_rounds(64, 1'b0);
      post_block_checks();

      // block B: random data, random valid gaps and back-pressure
      for (int i = 0; i < 16; i++) M[i] = $urandom;
      load_block(1'b1);
      run_rounds(64, 1'b1);
      post_block_checks();

      // reset in the middle of emission at r=30
      for (int i = 0; i < 16; i++) M[i] = $urandom;
      load_block(1'b1);
      run_rounds(30, 1'b1);
      check_round(30);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(o_valid),    64'd0);
      chk("midrst_in_ready",  64'(o_in_ready), 64'd0);
      chk("midrst_busy",      64'(o_busy),     64'd0);
      chk("midrst_out_round", 64'(o_round),    64'd0);
      chk("midrst_out_m",     64'(o_m),        64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) M[i] = $urandom;
      load_block(1'b0);
      run_rounds(64, 1'b0);
      post_block_checks();

      // reduced round count instance
      sel = 1'b1;
      nr  = 16;
      for (int i = 0; i < 16; i++) M[i] = $urandom;
      load_block(1'b1);
      run_rounds(16, 1'b1);
      post_block_checks();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
